// File: rtl/glyph_plotter.sv
// glyph_plotter
// Serialises one 8x16 character glyph into framebuffer pixel writes.
// A cell at text position (col, row) covers pixels x = col*8 .. col*8+7 and
// y = row*16 .. row*16+15. Pixels are scanned left to right, top to bottom.
//
// Ports:
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start, col, row    draw request and text-cell position (sampled in IDLE)
//   glyph              128-bit bitmap, [127:120] top row, bit 7 = leftmost
//   fg, bg             colours for set / clear bits
//   transparent        clear bits are skipped instead of painted bg
//   ready              pixel sink accepts the presented pixel this cycle
//   x, y, colour, plot registered pixel write
//   busy               cell in progress
//   done               one-cycle pulse after the last pixel is accepted
//   err                one-cycle pulse when start carries an off-grid cell
module glyph_plotter #(
  parameter int unsigned X_W  = 9,
  parameter int unsigned Y_W  = 8,
  parameter int unsigned COLS = 40,
  parameter int unsigned ROWS = 15,
  parameter int unsigned C_W  = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [5:0]     col,
  input  logic [3:0]     row,
  input  logic [127:0]   glyph,
  input  logic [C_W-1:0] fg,
  input  logic [C_W-1:0] bg,
  input  logic           transparent,
  input  logic           ready,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [C_W-1:0] colour,
  output logic           plot,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t         state_q, state_d;
  logic [127:0]   glyph_q;
  logic [C_W-1:0] fg_q, bg_q;
  logic           transp_q;
  logic [X_W-1:0] base_x;
  logic [Y_W-1:0] base_y;
  logic [2:0]     px, npx;
  logic [3:0]     py, npy;
  logic           start_ok, last, adv, nbit;

  always_comb begin
    start_ok = start && (32'(col) < COLS) && (32'(row) < ROWS);
    last     = (px == 3'd7) && (py == 4'd15);
    // A skipped (plot=0) pixel never waits on the sink.
    adv      = ready | ~plot;
    npx      = px + 3'd1;
    npy      = (px == 3'd7) ? py + 4'd1 : py;
    nbit     = glyph_q[7'd127 - {npy, npx}];

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = DRAW;
      DRAW:    if (adv && last) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Output registers are loaded with the pixel that becomes visible next,
  // so pixel 0 comes straight from the inputs on the accepting edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      glyph_q  <= '0;
      fg_q     <= '0;
      bg_q     <= '0;
      transp_q <= 1'b0;
      base_x   <= '0;
      base_y   <= '0;
      px       <= '0;
      py       <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            glyph_q  <= glyph;
            fg_q     <= fg;
            bg_q     <= bg;
            transp_q <= transparent;
            base_x   <= X_W'({col, 3'b000});
            base_y   <= Y_W'({row, 4'b0000});
            px       <= '0;
            py       <= '0;
            x        <= X_W'({col, 3'b000});
            y        <= Y_W'({row, 4'b0000});
            colour   <= glyph[127] ? fg : bg;
            plot     <= glyph[127] | ~transparent;
            busy     <= 1'b1;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        DRAW: begin
          if (adv) begin
            if (last) begin
              plot <= 1'b0;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              px     <= npx;
              py     <= npy;
              x      <= base_x + X_W'(npx);
              y      <= base_y + Y_W'(npy);
              colour <= nbit ? fg_q : bg_q;
              plot   <= nbit | ~transp_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_plotter.sv
module tb_glyph_plotter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic [5:0]   col;
  logic [3:0]   row;
  logic [127:0] glyph;
  logic [2:0]   fg, bg;
  logic         transparent;
  logic         ready;
  logic [8:0]   x;
  logic [7:0]   y;
  logic [2:0]   colour;
  logic         plot, busy, done, err;

  int checks = 0;
  int failures = 0;
  bit rdy [0:4095];

  glyph_plotter #(.X_W(9), .Y_W(8), .COLS(40), .ROWS(15), .C_W(3)) dut (
    .clk(clk), .resetn(resetn), .start(start), .col(col), .row(row),
    .glyph(glyph), .fg(fg), .bg(bg), .transparent(transparent), .ready(ready),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic fill_rdy(input int mode);
    bit pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4096; k++) begin
      case (mode)
        0:       rdy[k] = 1'b1;
        1:       rdy[k] = (k == 0) ? 1'b1 : pat[(k - 1) % 4];
        default: rdy[k] = ($urandom_range(0, 3) != 0);
      endcase
    end
  endtask

  // Draws one cell and checks every presented pixel against a list built
  // straight from the bitmap; the done cycle is predicted from the ready table.
  task automatic run_cell(input logic [5:0] c, input logic [3:0] r,
                          input logic [127:0] g, input logic [2:0] f,
                          input logic [2:0] b, input logic t, input bit inject,
                          input int abort_at, output int nplot,
                          output logic [19:0] last_pix);
    logic [19:0] q[$];
    int  exp_done, done_c, cyc, idx;
    bit  bitv, anyerr, aborted;
    nplot = 0; last_pix = '0; done_c = 0; anyerr = 0; aborted = 0;
    cyc = 1;
    for (int py = 0; py < 16; py++)
      for (int px = 0; px < 8; px++) begin
        idx  = 127 - (py * 8 + px);
        bitv = g[idx];
        if (bitv || !t) begin
          q.push_back({9'(c * 8 + px), 8'(r * 16 + py), bitv ? f : b});
          while (!rdy[cyc] && cyc < 4000) cyc++;
        end
        cyc++;
      end
    exp_done = cyc;

    @(negedge clk);
    col = c; row = r; glyph = g; fg = f; bg = b; transparent = t;
    start = 1'b1; ready = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      start = 1'b0;
      ready = rdy[k];
      if (inject) begin
        glyph = rnd128(); fg = 3'($urandom); bg = 3'($urandom);
        col = 6'($urandom_range(0, 39)); row = 4'($urandom_range(0, 14));
        transparent = 1'($urandom);
        if (k == 10 || k == 70) start = 1'b1;
      end
      if (k == abort_at) begin
        resetn = 1'b0;
        #1;
        chk("async_reset", {x, y, colour, plot, busy, done, err}, '0);
        aborted = 1;
        break;
      end
      if (done) begin
        done_c = k;
        break;
      end
      if (err) anyerr = 1;
      if (plot) begin
        chk("pixel", {x, y, colour}, (q.size() > 0) ? q[0] : 20'hxxxxx);
        if (ready && q.size() > 0) begin
          last_pix = q.pop_front();
          nplot++;
        end
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("done_cycle", done_c, exp_done);
      chk("busy_at_done", busy, 1'b0);
      chk("pixels_left", q.size(), 0);
      chk("no_err_busy", anyerr, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", {done, busy, plot}, 3'b000);
    end
  endtask

  initial begin
    int np;
    logic [19:0] lp;
    resetn = 1'b0; start = 1'b0; col = '0; row = '0; glyph = '0;
    fg = '0; bg = '0; transparent = 1'b0; ready = 1'b1;
    #2;
    chk("reset_state", {x, y, colour, plot, busy, done, err}, '0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // 'A' glyph, opaque, sink always ready.
    fill_rdy(0);
    run_cell(6'd0, 4'd0, 128'h0018_1824_243C_4242_4200_0000_0000_0000,
             3'd7, 3'd0, 1'b0, 1'b0, 0, np, lp);
    chk("A_plots", np, 128);

    // Bottom-right cell, solid.
    run_cell(6'd39, 4'd14, '1, 3'd5, 3'd2, 1'b0, 1'b0, 0, np, lp);
    chk("last_cell_plots", np, 128);
    chk("last_cell_corner", lp, {9'd319, 8'd239, 3'd5});

    // Sink stalls in a 1,0,0,1 pattern.
    fill_rdy(1);
    run_cell(6'd17, 4'd6, rnd128(), 3'd3, 3'd4, 1'b0, 1'b0, 0, np, lp);
    chk("stall_plots", np, 128);

    // '.' glyph, transparent; sink ready only where the two dots appear.
    for (int k = 0; k < 4096; k++) rdy[k] = (k == 60 || k == 68);
    run_cell(6'd2, 4'd3, 128'h0000_0000_0000_0010_1000_0000_0000_0000,
             3'd6, 3'd1, 1'b1, 1'b0, 0, np, lp);
    chk("dot_plots", np, 2);
    chk("dot_last", lp, {9'd19, 8'd56, 3'd6});

    // Off-grid requests.
    @(negedge clk); start = 1'b1; col = 6'd40; row = 4'd0;
    @(negedge clk); start = 1'b0;
    chk("err_col", {err, busy, plot}, 3'b100);
    @(negedge clk);
    chk("err_col_pulse", {err, busy, plot}, 3'b000);
    start = 1'b1; col = 6'd0; row = 4'd15;
    @(negedge clk); start = 1'b0;
    chk("err_row", {err, busy, plot}, 3'b100);
    @(negedge clk);
    chk("err_row_pulse", {err, busy, plot}, 3'b000);

    // Inputs churn and start is re-asserted while drawing.
    fill_rdy(2);
    run_cell(6'd25, 4'd9, rnd128(), 3'd2, 3'd5, 1'b0, 1'b1, 0, np, lp);
    chk("inject_plots", np, 128);

    // Reset while pixel 50 is presented.
    fill_rdy(0);
    run_cell(6'd8, 4'd4, rnd128(), 3'd7, 3'd1, 1'b0, 1'b0, 51, np, lp);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("held_reset", {plot, busy, done}, 3'b000);
    end
    resetn = 1'b1;
    run_cell(6'd0, 4'd0, rnd128(), 3'd4, 3'd3, 1'b0, 1'b0, 0, np, lp);
    chk("after_reset_plots", np, 128);

    // Random cells, random transparency and sink stalls.
    for (int n = 0; n < 4; n++) begin
      fill_rdy(2);
      run_cell(6'($urandom_range(0, 39)), 4'($urandom_range(0, 14)), rnd128(),
               3'($urandom), 3'($urandom), 1'($urandom), 1'b0, 0, np, lp);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glyph_plotter.md
Name: glyph_plotter

Overview:
Downstream consumer of the ASCII character decoder. It takes the 128-bit 8x16 glyph bitmap for one character cell and serialises it, one pixel per accepted cycle, into (x, y, colour, plot) writes for the VGA pixel-sink / framebuffer adapter. A cell is drawn at character coordinates (col, row) on a 320x240 screen laid out as a 40x15 text grid.

Parameters:
X_W, 9, width of pixel x coordinate (0..319)
Y_W, 8, width of pixel y coordinate (0..239)
COLS, 40, character columns; valid col is 0..COLS-1
ROWS, 15, character rows; valid row is 0..ROWS-1
C_W, 3, colour width

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request to draw one cell; sampled only in IDLE
col  input  6  character column of the cell
row  input  4  character row of the cell
glyph  input  128  bitmap from the char decoder; bits [127:120] = top row, bit 7 of each row byte = leftmost pixel
fg  input  C_W  colour for set bits
bg  input  C_W  colour for clear bits
transparent  input  1  when 1, clear bits are skipped (plot=0) rather than painted bg
ready  input  1  pixel sink accepts the presented pixel this cycle
x  output  X_W  pixel x
y  output  Y_W  pixel y
colour  output  C_W  pixel colour
plot  output  1  pixel valid
busy  output  1  cell draw in progress
done  output  1  one-cycle pulse when cell complete
err  output  1  one-cycle pulse when start rejected (col/row out of range)

Behaviour:
- Reset (async, resetn=0): state IDLE; x=0, y=0, colour=0, plot=0, busy=0, done=0, err=0; takes effect immediately, mid-draw included; partial cell is abandoned, no done.
- States: IDLE, DRAW, FIN.
- IDLE: on rising clk with start=1, col<COLS, row<ROWS: latch glyph, fg, bg, transparent, base_x=col*8, base_y=row*16; px=0, py=0; go DRAW; busy=1. start with col>=COLS or row>=ROWS: stay IDLE, err=1 for one cycle. start=0: hold.
- DRAW: presents pixel (px,py): x=base_x+px, y=base_y+py, bit=glyph_latched[127-(py*8+px)], colour = bit ? fg : bg; plot = bit | ~transparent. Outputs registered; pixel 0 visible the cycle after start sampled.
- Handshake: a pixel advances on an edge with ready=1; a plot=0 (transparent-skipped) pixel advances on every edge regardless of ready. While ready=0 and plot=1, x/y/colour/plot hold stable.
- Scan order: px 0..7 within a row, then py 0..15; px wraps 7->0 with py increment.
- After pixel (7,15) advances: go FIN; plot=0. FIN lasts one cycle: done=1, busy=0 in that cycle; then IDLE. Next start may be sampled on the FIN->IDLE edge's following cycle (i.e. in IDLE only).
- start while busy (DRAW/FIN): ignored, no err, no effect on latched data.
- Changes to glyph/fg/bg/col/row during DRAW have no effect (latched).
- Arithmetic: base_x=col<<3, base_y=row<<4, zero-extended to X_W/Y_W; no overflow for valid col/row (max x=319, y=239).
- Throughput with ready=1: start sampled edge 0, pixels on cycles 1..128, done on cycle 129.

Test Plan:
- 'A' (glyph row bytes 00,18,18,24,24,3C,42,42,42,00...) at col=0,row=0, fg=7,bg=0,transparent=0, ready=1 -> 128 plots cycles 1..128; (0,0)=0, (3,1)=7, (4,1)=7, (2,3)=7, (1,6)=7, (7,15)=0; done=1 on cycle 129, busy low same cycle.
- Last cell col=39,row=14, glyph all ones, fg=5 -> x spans 312..319, y 224..239, all colour 5, no wrap.
- ready toggled 1,0,0,1 repeatedly -> each pixel held during ready=0, scan order preserved, total accepted plots=128, done after last accept.
- '.' glyph (rows 7,8 = 00010000) with transparent=1 -> exactly 2 plots, at (3,7),(3,8) relative to base, colour fg; done at cycle 129 regardless of ready=0 on skipped pixels.
- col=40,row=0 start -> err=1 one cycle, busy stays 0, no plot; start again during DRAW of valid cell -> ignored.
- resetn low at pixel 50 -> plot/busy/done immediately 0, no done pulse; after release, new start draws a full cell from (0,0).
